// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped countdown timer with one-shot / auto-reload modes and masked irq
module tc_timer #(
    parameter int                 COUNT_W    = 32,
    parameter logic [COUNT_W-1:0] PRESET_RST = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           ctrl_q, ctrl_d;
    logic [COUNT_W-1:0]   preset_q, preset_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 pend_q, pend_d;

    logic                 en;
    logic                 auto_reload;

    assign en          = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'h0;
            preset_q <= PRESET_RST;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    // A bus write cycle freezes the FSM; only the written register changes.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        if (we) begin
            case (addr)
                2'd0: begin
                    ctrl_d = wdata[3:0];
                    pend_d = 1'b0;
                end
                2'd1:    preset_d = wdata[COUNT_W-1:0];
                default: ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) state_d = S_LOAD;
                end
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (!en) begin
                        state_d = S_IDLE;
                    end else if (count_q > COUNT_W'(1)) begin
                        count_d = count_q - COUNT_W'(1);
                    end else begin
                        // Terminal count of 0 or 1 both finish here, so COUNT never wraps.
                        count_d = '0;
                        pend_d  = 1'b1;
                        state_d = S_INT;
                    end
                end
                S_INT: begin
                    if (auto_reload) begin
                        pend_d  = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (addr)
            2'd0:    rdata = {28'h0, ctrl_q};
            2'd1:    rdata = 32'(preset_q);
            2'd2:    rdata = 32'(count_q);
            default: rdata = 32'h0;
        endcase
    end

    assign irq = pend_q & ctrl_q[3];

endmodule
